// File: rtl/game_ctrl.sv
// Game-logic controller for the two-row mod-10 number game; button edges drive a move FSM.
// States: IDLE wait start | INIT load board | PICK_SRC choose own digit | PICK_DST choose target | APPLY write | CHECK win test | END hold
module game_ctrl #(
    parameter logic [3:0] INIT_VAL    = 4'd1,
    parameter int         MAX_PER_ROW = 5
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic        start,
    input  logic [31:0] total_number,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    input  logic        btn_cancel,
    output logic [39:0] status,
    output logic        cur_player,
    output logic [31:0] cur_select,
    output logic [31:0] selected,
    output logic        selecting,
    output logic [3:0]  predict,
    output logic        predict_valid,
    output logic [1:0]  game_end,
    output logic [7:0]  move_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_PICK_SRC, S_PICK_DST, S_APPLY, S_CHECK, S_END
    } state_t;

    state_t      state_q;
    logic [6:0]  lvl_q;
    logic [2:0]  n_q;
    logic [39:0] status_q;
    logic        player_q;
    logic [3:0]  cur_q;
    logic [3:0]  src_q;
    logic        selecting_q;
    logic [3:0]  predict_q;
    logic        pvalid_q;
    logic [1:0]  end_q;
    logic [7:0]  mc_q;

    logic [6:0] lvl;
    logic [6:0] rise;
    logic       start_r, ok_r, cancel_r, vert_r, horz_r;

    assign lvl      = {start, btn_ok, btn_cancel, btn_up, btn_down, btn_left, btn_right};
    assign rise     = lvl & ~lvl_q;
    assign start_r  = rise[6];
    assign ok_r     = rise[5];
    assign cancel_r = rise[4];
    assign vert_r   = rise[3] ^ rise[2];
    assign horz_r   = rise[1] ^ rise[0];

    logic [2:0] n_clamp;
    logic       cur_row1;
    logic [3:0] cur_col;
    logic [3:0] col_next;
    logic [3:0] cur_d;
    logic [3:0] cur_digit;
    logic [3:0] src_digit;
    logic [4:0] sum5;
    logic [3:0] pred;
    logic       own_row;
    logic       src_ok;
    logic       dst_ok;
    logic       row0_zero;
    logic       row1_zero;

    always_comb begin
        if (total_number == 32'd0)
            n_clamp = 3'd1;
        else if (total_number > 32'(MAX_PER_ROW))
            n_clamp = 3'(MAX_PER_ROW);
        else
            n_clamp = total_number[2:0];

        cur_row1 = (cur_q >= 4'd5);
        cur_col  = cur_row1 ? cur_q - 4'd5 : cur_q;

        cur_digit = 4'd0;
        src_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (cur_q == 4'(k)) cur_digit = status_q[4*k +: 4];
            if (src_q == 4'(k)) src_digit = status_q[4*k +: 4];
        end

        // Sum in 5 bits so 9+9 cannot wrap before the mod-10 reduction.
        sum5    = {1'b0, src_digit} + {1'b0, cur_digit};
        pred    = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
        own_row = (cur_row1 == player_q);
        src_ok  = own_row && (cur_digit != 4'd0);
        dst_ok  = !own_row && (cur_digit != 4'd0);

        col_next = 4'd0;
        cur_d    = cur_q;
        if (vert_r) begin
            cur_d = cur_row1 ? cur_q - 4'd5 : cur_q + 4'd5;
        end else if (horz_r) begin
            if (rise[0])
                col_next = (cur_col == {1'b0, n_q} - 4'd1) ? 4'd0 : cur_col + 4'd1;
            else
                col_next = (cur_col == 4'd0) ? {1'b0, n_q} - 4'd1 : cur_col - 4'd1;
            cur_d = (cur_row1 ? 4'd5 : 4'd0) + col_next;
        end

        row0_zero = 1'b1;
        row1_zero = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(n_q)) begin
                if (status_q[4*k +: 4] != 4'd0)     row0_zero = 1'b0;
                if (status_q[4*(k+5) +: 4] != 4'd0) row1_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            state_q     <= S_IDLE;
            lvl_q       <= '0;
            n_q         <= 3'd1;
            status_q    <= '0;
            player_q    <= 1'b0;
            cur_q       <= 4'd0;
            src_q       <= 4'd0;
            selecting_q <= 1'b0;
            predict_q   <= 4'd0;
            pvalid_q    <= 1'b0;
            end_q       <= 2'd0;
            mc_q        <= 8'd0;
        end else begin
            lvl_q <= lvl;
            if (start_r) begin
                n_q     <= n_clamp;
                state_q <= S_INIT;
            end else begin
                case (state_q)
                    S_INIT: begin
                        for (int k = 0; k < 5; k++) begin
                            status_q[4*k +: 4]     <= (k < int'(n_q)) ? INIT_VAL : 4'd0;
                            status_q[4*(k+5) +: 4] <= (k < int'(n_q)) ? INIT_VAL : 4'd0;
                        end
                        player_q    <= 1'b0;
                        cur_q       <= 4'd0;
                        src_q       <= 4'd0;
                        selecting_q <= 1'b0;
                        predict_q   <= 4'd0;
                        pvalid_q    <= 1'b0;
                        mc_q        <= 8'd0;
                        end_q       <= 2'd0;
                        state_q     <= S_PICK_SRC;
                    end
                    S_PICK_SRC: begin
                        if (ok_r) begin
                            if (src_ok) begin
                                src_q       <= cur_q;
                                selecting_q <= 1'b1;
                                state_q     <= S_PICK_DST;
                            end
                        end else if (!cancel_r) begin
                            cur_q <= cur_d;
                        end
                    end
                    S_PICK_DST: begin
                        pvalid_q  <= dst_ok;
                        predict_q <= dst_ok ? pred : 4'd0;
                        if (ok_r) begin
                            if (dst_ok) state_q <= S_APPLY;
                        end else if (cancel_r) begin
                            selecting_q <= 1'b0;
                            pvalid_q    <= 1'b0;
                            predict_q   <= 4'd0;
                            state_q     <= S_PICK_SRC;
                        end else begin
                            cur_q <= cur_d;
                        end
                    end
                    S_APPLY: begin
                        for (int k = 0; k < 10; k++)
                            if (cur_q == 4'(k)) status_q[4*k +: 4] <= predict_q;
                        selecting_q <= 1'b0;
                        pvalid_q    <= 1'b0;
                        predict_q   <= 4'd0;
                        if (mc_q != 8'hFF) mc_q <= mc_q + 8'd1;
                        player_q <= ~player_q;
                        cur_q    <= player_q ? 4'd0 : 4'd5;
                        state_q  <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (row1_zero) begin
                            end_q   <= 2'd1;
                            state_q <= S_END;
                        end else if (row0_zero) begin
                            end_q   <= 2'd2;
                            state_q <= S_END;
                        end else begin
                            state_q <= S_PICK_SRC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign status        = status_q;
    assign cur_player    = player_q;
    assign cur_select    = {26'd0, cur_q, 2'b00};
    assign selected      = {26'd0, src_q, 2'b00};
    assign selecting     = selecting_q;
    assign predict       = predict_q;
    assign predict_valid = pvalid_q;
    assign game_end      = end_q;
    assign move_count    = mc_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a board model predicts each move; committed moves are scoreboarded.
module tb_game_ctrl;
    logic        vga_clk = 1'b0;
    logic        vga_rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] total_number = 32'd0;
    logic [5:0]  btn = 6'd0;
    logic [39:0] status;
    logic        cur_player;
    logic [31:0] cur_select;
    logic [31:0] selected;
    logic        selecting;
    logic [3:0]  predict;
    logic        predict_valid;
    logic [1:0]  game_end;
    logic [7:0]  move_count;

    localparam logic [5:0] B_OK     = 6'b100000;
    localparam logic [5:0] B_CANCEL = 6'b010000;
    localparam logic [5:0] B_UP     = 6'b001000;
    localparam logic [5:0] B_DOWN   = 6'b000100;
    localparam logic [5:0] B_LEFT   = 6'b000010;
    localparam logic [5:0] B_RIGHT  = 6'b000001;

    always #5 vga_clk = ~vga_clk;

    game_ctrl #(.INIT_VAL(4'd1), .MAX_PER_ROW(5)) dut (
        .vga_clk(vga_clk), .vga_rst(vga_rst), .start(start), .total_number(total_number),
        .btn_left(btn[1]), .btn_right(btn[0]), .btn_up(btn[3]), .btn_down(btn[2]),
        .btn_ok(btn[5]), .btn_cancel(btn[4]),
        .status(status), .cur_player(cur_player), .cur_select(cur_select),
        .selected(selected), .selecting(selecting), .predict(predict),
        .predict_valid(predict_valid), .game_end(game_end), .move_count(move_count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int brd[10];
    int m_n, m_player, m_cur, m_mc, m_end;

    typedef struct {
        logic [39:0] st;
        logic        pl;
        logic [7:0]  mc;
        logic [31:0] cs;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [39:0] pack_board();
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[4*k +: 4] = 4'(brd[k]);
        return r;
    endfunction

    function automatic int col_of(input int i);
        return (i >= 5) ? i - 5 : i;
    endfunction

    // Compares each committed move against the oldest prediction.
    logic [7:0] prev_mc = 8'd0;
    exp_t       mon_e;
    always @(negedge vga_clk) begin
        if (move_count == prev_mc + 8'd1) begin
            check_eq("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_eq("sb_status", status, mon_e.st);
                check_eq("sb_player", cur_player, mon_e.pl);
                check_eq("sb_moves", move_count, mon_e.mc);
                check_eq("sb_cursor", cur_select, mon_e.cs);
            end
        end
        prev_mc = move_count;
    end

    task automatic press(input logic [5:0] m);
        @(negedge vga_clk);
        btn = m;
        @(negedge vga_clk);
        btn = 6'd0;
    endtask

    task automatic press_start(input int tn);
        total_number = 32'(tn);
        @(negedge vga_clk);
        start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        @(negedge vga_clk);
        m_n = (tn == 0) ? 1 : (tn > 5 ? 5 : tn);
        for (int k = 0; k < 5; k++) begin
            brd[k]     = (k < m_n) ? 1 : 0;
            brd[k + 5] = (k < m_n) ? 1 : 0;
        end
        m_player = 0; m_cur = 0; m_mc = 0; m_end = 0;
    endtask

    task automatic goto(input int t);
        if ((m_cur >= 5) != (t >= 5)) begin
            press(B_DOWN);
            m_cur = (m_cur >= 5) ? m_cur - 5 : m_cur + 5;
        end
        for (int g = 0; g < 10 && col_of(m_cur) != col_of(t); g++) begin
            press(B_RIGHT);
            m_cur = ((m_cur >= 5) ? 5 : 0) + (col_of(m_cur) + 1) % m_n;
        end
        @(negedge vga_clk);
        check_eq("cursor", cur_select, 64'(4 * t));
    endtask

    task automatic do_move(input int s, input int d);
        exp_t e;
        bit   r0z, r1z;
        goto(s);
        press(B_OK);
        check_eq("selecting", selecting, 1);
        check_eq("selected", selected, 64'(4 * s));
        goto(d);
        check_eq("pred_valid", predict_valid, 1);
        check_eq("predict", predict, 64'((brd[s] + brd[d]) % 10));
        brd[d]   = (brd[s] + brd[d]) % 10;
        m_player = 1 - m_player;
        m_cur    = m_player ? 5 : 0;
        m_mc++;
        r0z = 1; r1z = 1;
        for (int k = 0; k < m_n; k++) begin
            if (brd[k] != 0)     r0z = 0;
            if (brd[k + 5] != 0) r1z = 0;
        end
        m_end = r1z ? 1 : (r0z ? 2 : 0);
        e.st = pack_board(); e.pl = 1'(m_player); e.mc = 8'(m_mc); e.cs = 32'(4 * m_cur);
        sb_q.push_back(e);
        press(B_OK);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("game_end", game_end, 64'(m_end));
    endtask

    initial begin
        repeat (3) @(negedge vga_clk);
        check_eq("rst_status", status, 0);
        check_eq("rst_player", cur_player, 0);
        check_eq("rst_cursor", cur_select, 0);
        check_eq("rst_selected", selected, 0);
        check_eq("rst_selecting", selecting, 0);
        check_eq("rst_predict", predict, 0);
        check_eq("rst_pvalid", predict_valid, 0);
        check_eq("rst_end", game_end, 0);
        check_eq("rst_moves", move_count, 0);
        vga_rst = 1'b0;
        @(negedge vga_clk);

        press_start(3);
        check_eq("init3_status", status, 40'h00111_00111);
        check_eq("init3_player", cur_player, 0);
        check_eq("init3_cursor", cur_select, 0);
        check_eq("init3_end", game_end, 0);

        press(B_RIGHT); check_eq("right1", cur_select, 4);
        press(B_RIGHT); check_eq("right2", cur_select, 8);
        press(B_RIGHT); check_eq("right_wrap", cur_select, 0);
        press(B_DOWN);  check_eq("down", cur_select, 20);
        press(B_UP);    check_eq("up", cur_select, 0);

        do_move(1, 6);

        // Player 1 to move: opponent-row ok, then ok+left together, must both be no-ops.
        goto(0);
        press(B_OK);
        check_eq("opp_ok_sel", selecting, 0);
        press(B_OK | B_LEFT);
        check_eq("okleft_cursor", cur_select, 0);
        check_eq("okleft_sel", selecting, 0);

        goto(5);
        press(B_OK);
        check_eq("src5_sel", selecting, 1);
        goto(7);
        check_eq("own_pvalid", predict_valid, 0);
        press(B_OK);
        check_eq("own_ok_sel", selecting, 1);
        check_eq("own_ok_moves", move_count, 1);
        press(B_CANCEL);
        check_eq("cancel_sel", selecting, 0);
        check_eq("cancel_cursor", cur_select, 28);
        check_eq("cancel_pvalid", predict_valid, 0);

        press_start(7);
        check_eq("init5_status", status, 40'h11111_11111);
        do_move(0, 5); do_move(6, 0); do_move(0, 5);
        do_move(6, 1); do_move(3, 5); do_move(5, 0);
        do_move(0, 5);
        check_eq("wrap_7p5", status[23:20], 2);
        do_move(5, 0);
        do_move(0, 6);
        check_eq("wrap_9p1", status[27:24], 0);
        goto(6);
        press(B_OK);
        check_eq("zero_src_sel", selecting, 0);

        press_start(0);
        check_eq("init1_status", status, 40'h00001_00001);
        for (int i = 0; i < 30 && m_end == 0; i++) begin
            if (m_player == 0) do_move(0, 5);
            else               do_move(5, 0);
        end
        check_eq("win_end", game_end, 1);
        check_eq("win_moves", move_count, 13);
        press(B_RIGHT);
        press(B_OK);
        check_eq("end_cursor", cur_select, 20);
        check_eq("end_status", status, pack_board());
        check_eq("end_hold", game_end, 1);

        press_start(2);
        do_move(0, 5);
        @(posedge vga_clk);
        #2 vga_rst = 1'b1;
        #1;
        check_eq("arst_status", status, 0);
        check_eq("arst_moves", move_count, 0);
        check_eq("arst_player", cur_player, 0);
        check_eq("arst_cursor", cur_select, 0);
        check_eq("arst_end", game_end, 0);
        @(negedge vga_clk);
        vga_rst = 1'b0;
        @(negedge vga_clk);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
